// File: rtl/clk_src_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : clk_src_supervisor
// Purpose  : Supervises N_SRC candidate clock sources. Each source is
//            qualified from its MMCM lock and input-stopped flags. The active
//            source is chosen either by a manual force request or by
//            priority, where index 0 is the highest priority. The block
//            drives one-hot, break-before-make select lines for a
//            global-buffer mux tree. It also pulses the MMCM reset of a
//            selected source that fails. Everything runs on the
//            free-running system clock.
// Ports    : clk          system clock
//            rst          synchronous active-high reset
//            src_locked   per-source MMCM LOCKED, already synchronised
//            src_stopped  per-source CLKINSTOPPED, already synchronised
//            force_en     request manual selection of force_sel
//            force_sel    manual source index
//            src_healthy  qualified-source flags (registered)
//            sel_onehot   mux select lines, at most one bit high
//            sel_idx      index of the current source (valid with sel_valid)
//            sel_valid    a source is driving the output clock
//            mmcm_rst     active-high MMCM reset pulses, one per source
//            switch_count saturating count of deselect events
// Revision : 1.0  initial release
// ============================================================================
module clk_src_supervisor #(
    parameter int N_SRC       = 4,
    parameter int QUAL_CYCLES = 1024,
    parameter int SWITCH_HOLD = 64,
    parameter int RST_PULSE   = 16,
    parameter int REVERTIVE   = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_locked,
    input  logic [N_SRC-1:0]           src_stopped,
    input  logic                       force_en,
    input  logic [$clog2(N_SRC)-1:0]   force_sel,
    output logic [N_SRC-1:0]           src_healthy,
    output logic [N_SRC-1:0]           sel_onehot,
    output logic [$clog2(N_SRC)-1:0]   sel_idx,
    output logic                       sel_valid,
    output logic [N_SRC-1:0]           mmcm_rst,
    output logic [CNT_W-1:0]           switch_count
);

    localparam int c_IDX_W  = $clog2(N_SRC);
    localparam int c_QCNT_W = $clog2(QUAL_CYCLES + 1);
    localparam int c_HCNT_W = $clog2(SWITCH_HOLD + 1);
    localparam int c_PCNT_W = $clog2(RST_PULSE + 1);

    localparam logic [c_QCNT_W-1:0] c_QMAX      = c_QCNT_W'(QUAL_CYCLES);
    localparam logic [c_PCNT_W-1:0] c_PMAX      = c_PCNT_W'(RST_PULSE);
    // The gap counter is loaded one short so that the gap lasts exactly
    // SWITCH_HOLD cycles. The counter reaching zero is itself the last gap
    // cycle.
    localparam logic [c_HCNT_W-1:0] c_HOLD_LOAD = c_HCNT_W'(SWITCH_HOLD - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_GAP  = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    // ------------------------------------------------------------------------
    // Source qualification and per-source MMCM reset pulse generation
    // ------------------------------------------------------------------------
    logic [N_SRC-1:0] w_raw_ok;
    logic [N_SRC-1:0] w_healthy_d;
    logic [N_SRC-1:0] r_healthy_q;
    logic [N_SRC-1:0] w_pulse_start;

    assign w_raw_ok = src_locked & ~src_stopped;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            logic [c_QCNT_W-1:0] r_qcnt_q;
            logic [c_QCNT_W-1:0] w_qcnt_d;
            logic [c_PCNT_W-1:0] r_pcnt_q;
            logic [c_PCNT_W-1:0] w_pcnt_d;

            always_comb begin
                w_qcnt_d = r_qcnt_q;
                if (!w_raw_ok[gi]) begin
                    w_qcnt_d = '0;
                end else if (r_qcnt_q != c_QMAX) begin
                    w_qcnt_d = r_qcnt_q + 1'b1;
                end
            end

            // Healthy is taken from the next count value. It therefore
            // rises on the very edge that completes qualification, and it
            // falls on the first bad sample.
            assign w_healthy_d[gi] = (w_qcnt_d == c_QMAX);

            always_comb begin
                w_pcnt_d = r_pcnt_q;
                if (w_pulse_start[gi]) begin
                    w_pcnt_d = c_PMAX;
                end else if (r_pcnt_q != '0) begin
                    w_pcnt_d = r_pcnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_qcnt_q <= '0;
                    r_pcnt_q <= '0;
                end else begin
                    r_qcnt_q <= w_qcnt_d;
                    r_pcnt_q <= w_pcnt_d;
                end
            end

            assign mmcm_rst[gi] = (r_pcnt_q != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_healthy_q <= '0;
        end else begin
            r_healthy_q <= w_healthy_d;
        end
    end

    assign src_healthy = r_healthy_q;

    // ------------------------------------------------------------------------
    // Target selection: a valid, healthy force wins; otherwise the lowest
    // healthy index is chosen. An invalid force behaves as no force at all.
    // ------------------------------------------------------------------------
    logic               w_force_ok;
    logic               w_tgt_valid;
    logic [c_IDX_W-1:0] w_tgt_idx;

    always_comb begin
        w_force_ok = 1'b0;
        if (force_en && (int'(force_sel) < N_SRC)) begin
            w_force_ok = r_healthy_q[force_sel];
        end
        w_tgt_valid = |r_healthy_q;
        w_tgt_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (r_healthy_q[i]) begin
                w_tgt_idx = c_IDX_W'(i);
            end
        end
        if (w_force_ok) begin
            w_tgt_idx = force_sel;
        end
    end

    // ------------------------------------------------------------------------
    // Selection FSM: state register
    // ------------------------------------------------------------------------
    logic [1:0]          r_state_q;
    logic [1:0]          w_state_d;
    logic [c_HCNT_W-1:0] r_hold_q;
    logic [c_HCNT_W-1:0] w_hold_d;
    logic [c_IDX_W-1:0]  r_cur_q;
    logic [c_IDX_W-1:0]  w_cur_d;
    logic [CNT_W-1:0]    r_swcnt_q;
    logic [CNT_W-1:0]    w_swcnt_d;
    logic                w_desel;
    logic                w_cur_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
            r_hold_q  <= '0;
            r_cur_q   <= '0;
            r_swcnt_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_hold_q  <= w_hold_d;
            r_cur_q   <= w_cur_d;
            r_swcnt_q <= w_swcnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Selection FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_hold_d   = r_hold_q;
        w_cur_d    = r_cur_q;
        w_desel    = 1'b0;
        w_cur_fail = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_tgt_valid) begin
                    w_state_d = c_ST_GAP;
                    w_hold_d  = c_HOLD_LOAD;
                end
            end
            c_ST_GAP: begin
                // The target is sampled only when the gap expires. A source
                // that drops out during the gap is therefore never picked.
                if (r_hold_q == '0) begin
                    if (w_tgt_valid) begin
                        w_state_d = c_ST_RUN;
                        w_cur_d   = w_tgt_idx;
                    end else begin
                        w_state_d = c_ST_IDLE;
                    end
                end else begin
                    w_hold_d = r_hold_q - 1'b1;
                end
            end
            c_ST_RUN: begin
                // Failure takes precedence over a voluntary switch. This
                // means a coincident force change still pulses the reset,
                // and the count is bumped once.
                if (!r_healthy_q[r_cur_q]) begin
                    w_state_d  = c_ST_GAP;
                    w_hold_d   = c_HOLD_LOAD;
                    w_desel    = 1'b1;
                    w_cur_fail = 1'b1;
                end else if (w_tgt_valid && (w_tgt_idx != r_cur_q) &&
                             (w_force_ok || ((REVERTIVE != 0) && (w_tgt_idx < r_cur_q)))) begin
                    w_state_d = c_ST_GAP;
                    w_hold_d  = c_HOLD_LOAD;
                    w_desel   = 1'b1;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        w_pulse_start = '0;
        if (w_cur_fail) begin
            w_pulse_start[r_cur_q] = 1'b1;
        end
    end

    always_comb begin
        w_swcnt_d = r_swcnt_q;
        if (w_desel && (r_swcnt_q != {CNT_W{1'b1}})) begin
            w_swcnt_d = r_swcnt_q + 1'b1;
        end
    end

    assign switch_count = r_swcnt_q;

    // ------------------------------------------------------------------------
    // Selection FSM: outputs (selects are live only while RUN)
    // ------------------------------------------------------------------------
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
        if (r_state_q == c_ST_RUN) begin
            sel_onehot[r_cur_q] = 1'b1;
            sel_idx             = r_cur_q;
            sel_valid           = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_src_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_src_supervisor
// Purpose  : Scoreboard bench for clk_src_supervisor. The parameters are
//            N_SRC=4, QUAL_CYCLES=8, SWITCH_HOLD=4 and RST_PULSE=3. Two
//            instances are used: a revertive one and a non-revertive one.
//            Both share the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_src_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_locked;
    logic [3:0] src_stopped;
    logic       force_en;
    logic [1:0] force_sel;

    logic [3:0]  src_healthy, sel_onehot, mmcm_rst;
    logic [1:0]  sel_idx;
    logic        sel_valid;
    logic [15:0] switch_count;

    logic [3:0]  nr_healthy, nr_onehot, nr_mmcm_rst;
    logic [1:0]  nr_idx;
    logic        nr_valid;
    logic [15:0] nr_count;

    always #5 clk = ~clk;

    clk_src_supervisor #(
        .N_SRC(4), .QUAL_CYCLES(8), .SWITCH_HOLD(4), .RST_PULSE(3),
        .REVERTIVE(1), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .src_locked(src_locked), .src_stopped(src_stopped),
        .force_en(force_en), .force_sel(force_sel), .src_healthy(src_healthy),
        .sel_onehot(sel_onehot), .sel_idx(sel_idx), .sel_valid(sel_valid),
        .mmcm_rst(mmcm_rst), .switch_count(switch_count)
    );

    clk_src_supervisor #(
        .N_SRC(4), .QUAL_CYCLES(8), .SWITCH_HOLD(4), .RST_PULSE(3),
        .REVERTIVE(0), .CNT_W(16)
    ) u_dut_nr (
        .clk(clk), .rst(rst), .src_locked(src_locked), .src_stopped(src_stopped),
        .force_en(force_en), .force_sel(force_sel), .src_healthy(nr_healthy),
        .sel_onehot(nr_onehot), .sel_idx(nr_idx), .sel_valid(nr_valid),
        .mmcm_rst(nr_mmcm_rst), .switch_count(nr_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  oh;
        logic [1:0]  idx;
        logic        vld;
        logic [3:0]  mrst;
        logic [15:0] cnt;
        logic [3:0]  hl;
        logic        nr_chk;
        logic [3:0]  nr_oh;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, req);
        end
    endtask

    // Queue the expected DUT state for the negedge 'dly' edges from now.
    task automatic push(input int dly, input logic [3:0] oh, input logic [1:0] idx,
                        input logic [3:0] mrst, input int cnt, input logic [3:0] hl,
                        input logic nr_chk = 1'b0, input logic [3:0] nr_oh = 4'b0);
        exp_t e;
        e.cyc    = cyc + dly;
        e.oh     = oh;
        e.idx    = idx;
        e.vld    = (oh != 4'b0);
        e.mrst   = mrst;
        e.cnt    = 16'(cnt);
        e.hl     = hl;
        e.nr_chk = nr_chk;
        e.nr_oh  = nr_oh;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle invariants plus scoreboard comparison at the tagged cycle.
    logic [3:0] prev_oh  = 4'b0;
    int         zero_run = 1000;

    always @(negedge clk) begin
        exp_t e;
        chk("onehot0", 32'($onehot0(sel_onehot)), 32'd1);
        chk("valid_vs_onehot", 32'(sel_valid), 32'(|sel_onehot));
        chk("nr_onehot0", 32'($onehot0(nr_onehot)), 32'd1);
        if (sel_onehot != 4'b0 && prev_oh == 4'b0)
            chk("bbm_gap_ge4", 32'(zero_run >= 4), 32'd1);
        if (sel_onehot != 4'b0 && prev_oh != 4'b0)
            chk("bbm_direct", 32'(sel_onehot), 32'(prev_oh));
        zero_run = (sel_onehot == 4'b0) ? zero_run + 1 : 0;
        prev_oh  = sel_onehot;

        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                chk("sb_missed_slot", 32'(cyc), 32'(e.cyc));
            end else begin
                chk("sel_onehot", 32'(sel_onehot), 32'(e.oh));
                chk("sel_valid", 32'(sel_valid), 32'(e.vld));
                if (e.vld) chk("sel_idx", 32'(sel_idx), 32'(e.idx));
                chk("mmcm_rst", 32'(mmcm_rst), 32'(e.mrst));
                chk("switch_count", 32'(switch_count), 32'(e.cnt));
                chk("src_healthy", 32'(src_healthy), 32'(e.hl));
                if (e.nr_chk) chk("nr_sel_onehot", 32'(nr_onehot), 32'(e.nr_oh));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; src_locked = 4'b0; src_stopped = 4'b0; force_en = 1'b0; force_sel = 2'd0;
        tick(3);
        push(0, 4'b0000, 2'd0, 4'b0000, 0, 4'b0000);          // reset state
        tick(1);

        // Src1 alone qualifies at +8 and is selected at +13.
        rst = 1'b0; src_locked = 4'b0010;
        push(7,  4'b0000, 2'd0, 4'b0000, 0, 4'b0000);
        push(8,  4'b0000, 2'd0, 4'b0000, 0, 4'b0010);
        push(12, 4'b0000, 2'd0, 4'b0000, 0, 4'b0010);
        push(13, 4'b0010, 2'd1, 4'b0000, 0, 4'b0010);
        tick(20);

        // Src0 qualifies: the revertive instance moves to 0, the other stays on 1.
        src_locked = 4'b0011;
        push(8,  4'b0010, 2'd1, 4'b0000, 0, 4'b0011);
        push(9,  4'b0000, 2'd0, 4'b0000, 1, 4'b0011);
        push(12, 4'b0000, 2'd0, 4'b0000, 1, 4'b0011);
        push(13, 4'b0001, 2'd0, 4'b0000, 1, 4'b0011, 1'b1, 4'b0010);
        tick(20);

        // One-cycle stop on src0: 3-cycle reset pulse, fall back to 1, then revert.
        src_stopped = 4'b0001;
        push(1,  4'b0001, 2'd0, 4'b0000, 1, 4'b0010);
        push(2,  4'b0000, 2'd0, 4'b0001, 2, 4'b0010);
        push(4,  4'b0000, 2'd0, 4'b0001, 2, 4'b0010);
        push(5,  4'b0000, 2'd0, 4'b0000, 2, 4'b0010);
        push(6,  4'b0010, 2'd1, 4'b0000, 2, 4'b0010);
        push(9,  4'b0010, 2'd1, 4'b0000, 2, 4'b0011);
        push(10, 4'b0000, 2'd0, 4'b0000, 3, 4'b0011);
        push(14, 4'b0001, 2'd0, 4'b0000, 3, 4'b0011);
        tick(1);
        src_stopped = 4'b0000;
        tick(19);

        // Force src2; it becomes effective only once src2 is healthy.
        src_locked = 4'b0111; force_en = 1'b1; force_sel = 2'd2;
        push(8,  4'b0001, 2'd0, 4'b0000, 3, 4'b0111);
        push(9,  4'b0000, 2'd0, 4'b0000, 4, 4'b0111);
        push(13, 4'b0100, 2'd2, 4'b0000, 4, 4'b0111);
        tick(20);

        // Release force: revert to priority source 0.
        force_en = 1'b0;
        push(1,  4'b0000, 2'd0, 4'b0000, 5, 4'b0111);
        push(5,  4'b0001, 2'd0, 4'b0000, 5, 4'b0111);
        tick(20);

        // Force an unhealthy source: ignored.
        force_en = 1'b1; force_sel = 2'd3;
        push(10, 4'b0001, 2'd0, 4'b0000, 5, 4'b0111);
        tick(20);

        // Src0 fails, then every source drops during the gap: IDLE with no extra count.
        force_en = 1'b0; src_locked = 4'b0110;
        push(1,  4'b0001, 2'd0, 4'b0000, 5, 4'b0110);
        push(2,  4'b0000, 2'd0, 4'b0001, 6, 4'b0110);
        push(4,  4'b0000, 2'd0, 4'b0001, 6, 4'b0000);
        push(5,  4'b0000, 2'd0, 4'b0000, 6, 4'b0000);
        push(6,  4'b0000, 2'd0, 4'b0000, 6, 4'b0000);
        push(10, 4'b0000, 2'd0, 4'b0000, 6, 4'b0000);
        tick(3);
        src_locked = 4'b0000;
        tick(17);

        // Src3 alone is selected; rst in RUN clears everything; src3 is requalified afterwards.
        src_locked = 4'b1000;
        push(13, 4'b1000, 2'd3, 4'b0000, 6, 4'b1000);
        push(16, 4'b0000, 2'd0, 4'b0000, 0, 4'b0000);
        push(29, 4'b1000, 2'd3, 4'b0000, 0, 4'b1000);
        tick(15);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);

        // Random ok/stop/force traffic; only the invariants are checked here.
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 15) == 0) src_locked = 4'($urandom);
            src_stopped = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 63) == 0) begin
                force_en  = 1'($urandom);
                force_sel = 2'($urandom);
            end
            tick(1);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
